// File: rtl/writeburst_arbiter.sv
// writeburst_arbiter: round-robin two-port arbiter onto one writeburst channel.
// Grant held for a whole burst; response side is driven only from registers.
module writeburst_arbiter (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_writeburst_do,
  output logic        req0_writeburst_done,
  input  logic [31:0] req0_writeburst_address,
  input  logic [1:0]  req0_writeburst_dword_length,
  input  logic [3:0]  req0_writeburst_byteenable_0,
  input  logic [3:0]  req0_writeburst_byteenable_1,
  input  logic [55:0] req0_writeburst_data,

  input  logic        req1_writeburst_do,
  output logic        req1_writeburst_done,
  input  logic [31:0] req1_writeburst_address,
  input  logic [1:0]  req1_writeburst_dword_length,
  input  logic [3:0]  req1_writeburst_byteenable_0,
  input  logic [3:0]  req1_writeburst_byteenable_1,
  input  logic [55:0] req1_writeburst_data,

  output logic        resp_writeburst_do,
  input  logic        resp_writeburst_done,
  output logic [31:0] resp_writeburst_address,
  output logic [1:0]  resp_writeburst_dword_length,
  output logic [3:0]  resp_writeburst_byteenable_0,
  output logic [3:0]  resp_writeburst_byteenable_1,
  output logic [55:0] resp_writeburst_data,

  output logic        grant_id
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0] state;
  logic       last_grant;
  logic       any_req;
  logic       both_req;
  logic       pick;

  assign any_req  = req0_writeburst_do | req1_writeburst_do;
  assign both_req = req0_writeburst_do & req1_writeburst_do;

  // on contention the port that did not win last time goes first
  assign pick = both_req ? ~last_grant : req1_writeburst_do;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                        <= IDLE;
      last_grant                   <= 1'b1;
      grant_id                     <= 1'b0;
      resp_writeburst_do           <= 1'b0;
      req0_writeburst_done         <= 1'b0;
      req1_writeburst_done         <= 1'b0;
      resp_writeburst_address      <= '0;
      resp_writeburst_dword_length <= '0;
      resp_writeburst_byteenable_0 <= '0;
      resp_writeburst_byteenable_1 <= '0;
      resp_writeburst_data         <= '0;
    end else begin
      req0_writeburst_done <= 1'b0;
      req1_writeburst_done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state              <= BUSY;
            grant_id           <= pick;
            last_grant         <= pick;
            resp_writeburst_do <= 1'b1;
            if (pick) begin
              resp_writeburst_address      <= req1_writeburst_address;
              resp_writeburst_dword_length <= req1_writeburst_dword_length;
              resp_writeburst_byteenable_0 <= req1_writeburst_byteenable_0;
              resp_writeburst_byteenable_1 <= req1_writeburst_byteenable_1;
              resp_writeburst_data         <= req1_writeburst_data;
            end else begin
              resp_writeburst_address      <= req0_writeburst_address;
              resp_writeburst_dword_length <= req0_writeburst_dword_length;
              resp_writeburst_byteenable_0 <= req0_writeburst_byteenable_0;
              resp_writeburst_byteenable_1 <= req0_writeburst_byteenable_1;
              resp_writeburst_data         <= req0_writeburst_data;
            end
          end
        end
        BUSY: begin
          if (resp_writeburst_done) begin
            state                <= RELEASE;
            resp_writeburst_do   <= 1'b0;
            req0_writeburst_done <= ~grant_id;
            req1_writeburst_done <= grant_id;
          end
        end
        // requests are not sampled here, so a lingering do is not re-granted
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
